// File: rtl/alu_exec_unit_if.sv
// Operation/result bundle between register-read and writeback for alu_exec_unit.
// Issue side uses valid/ready; the result side holds until out_ready.
interface alu_exec_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       mode;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] ex_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [2:0]       flags;
    logic             busy;

    modport master (
        output in_valid, mode, s1, s2, imm, ex_in, out_ready,
        input  in_ready, out_valid, result, flags, busy
    );

    modport slave (
        input  in_valid, mode, s1, s2, imm, ex_in, out_ready,
        output in_ready, out_valid, result, flags, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Registered execute ALU with persistent {Z,N,C} flags; one op in flight, result 1 cycle after accept
// (amt+1 for iterative shifts when ALU_SHIFT_MULTI_EN is defined); result held until out_ready.
module alu_exec_unit #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input logic            clk,
    input logic            rst,
    alu_exec_unit_if.slave bus
);

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_NAND = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_IN   = 4'h7;
    localparam logic [3:0] OP_MOVE = 4'h8;
    localparam logic [3:0] OP_STOR = 4'hE;
    localparam logic [3:0] OP_LDI  = 4'hF;

    if (2**SHW < WIDTH) begin : g_shw_check
        $error("SHW too narrow to express a full-width shift");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       flags_q, flags_d;
    logic             accept;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] nand_res;

    function automatic logic [2:0] mk_flags(input logic [WIDTH-1:0] r, input logic c);
        return {r == '0, r[WIDTH-1], c};
    endfunction

    assign accept   = bus.in_valid && bus.in_ready;
    assign sum      = {1'b0, bus.s1} + {1'b0, bus.s2};
    // top bit of the widened difference is the unsigned borrow
    assign diff     = {1'b0, bus.s1} - {1'b0, bus.s2};
    assign nand_res = ~(bus.s1 & bus.s2);

`ifdef ALU_SHIFT_MULTI_EN
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] sh_res;
    logic             sh_c;

    assign amt    = bus.imm[SHW-1:0];
    assign sh_res = dir_q ? (result_q >> 1) : (result_q << 1);
    assign sh_c   = dir_q ? result_q[0] : result_q[WIDTH-1];
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
`ifdef ALU_SHIFT_MULTI_EN
        cnt_d    = cnt_q;
        dir_d    = dir_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_DONE;
                    case (bus.mode)
                        OP_IN:   result_d = bus.ex_in;
                        OP_STOR: result_d = bus.s1;
                        OP_LDI:  result_d = bus.imm;
                        OP_MOVE: result_d = bus.s2;
                        OP_ADD: begin
                            result_d = sum[WIDTH-1:0];
                            flags_d  = mk_flags(sum[WIDTH-1:0], sum[WIDTH]);
                        end
                        OP_SUB: begin
                            result_d = diff[WIDTH-1:0];
                            flags_d  = mk_flags(diff[WIDTH-1:0], diff[WIDTH]);
                        end
                        OP_NAND: begin
                            result_d = nand_res;
                            flags_d  = mk_flags(nand_res, 1'b0);
                        end
                        OP_SHL, OP_SHR: begin
`ifdef ALU_SHIFT_MULTI_EN
                            // the result register doubles as the shift working register
                            result_d = bus.s1;
                            if (amt == '0) begin
                                flags_d = mk_flags(bus.s1, 1'b0);
                            end else begin
                                state_d = S_SHIFT;
                                cnt_d   = amt;
                                dir_d   = (bus.mode == OP_SHR);
                            end
`else
                            if (bus.mode == OP_SHL) begin
                                result_d = bus.s1 << 1;
                                flags_d  = mk_flags(bus.s1 << 1, bus.s1[WIDTH-1]);
                            end else begin
                                result_d = bus.s1 >> 1;
                                flags_d  = mk_flags(bus.s1 >> 1, bus.s1[0]);
                            end
`endif
                        end
                        default: result_d = '0;
                    endcase
                end
            end
`ifdef ALU_SHIFT_MULTI_EN
            S_SHIFT: begin
                result_d = sh_res;
                cnt_d    = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = S_DONE;
                    flags_d = mk_flags(sh_res, sh_c);
                end
            end
`endif
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

`ifdef ALU_SHIFT_MULTI_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            dir_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    assign bus.busy = (state_q == S_SHIFT);
`else
    assign bus.busy = 1'b0;
`endif

    assign bus.in_ready  = (state_q == S_IDLE) && !rst;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and random operations against a reference model, with a scoreboard of expected results.
module tb_alu_exec_unit;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic [2:0]   flags;
        int           lat;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];
    logic [2:0]   mflags;
    logic [W-1:0] last_res;
    logic [2:0]   last_flags;

    alu_exec_unit_if #(.WIDTH(W)) bus();

    alu_exec_unit #(.WIDTH(W), .SHW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [3:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] im, input logic [W-1:0] ex, output exp_t e);
        logic [W:0]   w;
        logic [W-1:0] r;
        logic         c;
        bit           upd;
        int           amt;
        c   = 1'b0;
        upd = 1'b1;
        e.lat = 1;
        case (m)
            4'h1: begin w = {1'b0, a} + {1'b0, b}; r = w[W-1:0]; c = w[W]; end
            4'h2: begin r = a - b; c = (a < b); end
            4'h3: r = ~(a & b);
            4'h4, 4'h5: begin
`ifdef ALU_SHIFT_MULTI_EN
                amt = int'(im[2:0]);
                e.lat = amt + 1;
                if (m == 4'h4) begin
                    r = (amt >= W) ? '0 : (a << amt);
                    c = (amt >= 1 && amt <= W) ? a[W-amt] : 1'b0;
                end else begin
                    r = (amt >= W) ? '0 : (a >> amt);
                    c = (amt >= 1 && amt <= W) ? a[amt-1] : 1'b0;
                end
`else
                amt = 1;
                r = (m == 4'h4) ? (a << amt) : (a >> amt);
                c = (m == 4'h4) ? a[W-1] : a[0];
`endif
            end
            4'h7: begin r = ex; upd = 1'b0; end
            4'h8: begin r = b;  upd = 1'b0; end
            4'hE: begin r = a;  upd = 1'b0; end
            4'hF: begin r = im; upd = 1'b0; end
            default: begin r = '0; upd = 1'b0; end
        endcase
        if (upd) mflags = {r == '0, r[W-1], c};
        e.res   = r;
        e.flags = mflags;
    endtask

    // Called just after a rising edge with the unit idle; returns just after a rising edge.
    task automatic issue(input string tag, input logic [3:0] m, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] im, input logic [W-1:0] ex,
                         input int hold);
        exp_t e;
        exp_t got;
        int   lat;
        int   busy_cnt;
        bit   seen;
        model(m, a, b, im, ex, e);
        sb.push_back(e);
        bus.mode = m; bus.s1 = a; bus.s2 = b; bus.imm = im; bus.ex_in = ex;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check({tag, ":in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.mode = 4'($urandom); bus.s1 = W'($urandom); bus.s2 = W'($urandom);
        bus.imm = W'($urandom); bus.ex_in = W'($urandom);
        lat = 1; busy_cnt = 0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        got = sb.pop_front();
        if (!seen) begin
            checks++;
            errors++;
            $error("FAIL %s:timeout observed=no out_valid expected=out_valid", tag);
            return;
        end
        check({tag, ":result"}, 32'(bus.result), 32'(got.res));
        check({tag, ":flags"}, 32'(bus.flags), 32'(got.flags));
        check({tag, ":latency"}, lat, got.lat);
        check({tag, ":busy_cycles"}, busy_cnt, got.lat - 1);
        last_res   = bus.result;
        last_flags = bus.flags;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check({tag, ":hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, ":hold_result"}, 32'(bus.result), 32'(got.res));
            check({tag, ":hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mflags = 3'b000;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.mode = 4'h0;
        bus.s1 = '0; bus.s2 = '0; bus.imm = '0; bus.ex_in = '0;
        #3;
        check("reset:result", 32'(bus.result), 32'h0);
        check("reset:flags", 32'(bus.flags), 32'h0);
        check("reset:out_valid", 32'(bus.out_valid), 32'h0);
        check("reset:busy", 32'(bus.busy), 32'h0);
        check("reset:in_ready", 32'(bus.in_ready), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_release:in_ready", 32'(bus.in_ready), 32'h1);
        @(posedge clk); #1;

        issue("add", 4'h1, 8'hF0, 8'h10, 8'h00, 8'h00, 3);
        check("add:lit_result", 32'(last_res), 32'h00);
        check("add:lit_flags", 32'(last_flags), 32'h5);
        issue("sub", 4'h2, 8'h03, 8'h05, 8'h00, 8'h00, 0);
        check("sub:lit_result", 32'(last_res), 32'hFE);
        check("sub:lit_flags", 32'(last_flags), 32'h3);
        issue("ldi", 4'hF, 8'h11, 8'h22, 8'h00, 8'h33, 0);
        check("ldi:lit_flags", 32'(last_flags), 32'h3);
        issue("in",   4'h7, 8'h11, 8'h22, 8'h44, 8'h5A, 0);
        issue("move", 4'h8, 8'h11, 8'h3C, 8'h44, 8'h5A, 0);
        issue("stor", 4'hE, 8'h77, 8'h3C, 8'h44, 8'h5A, 1);
        issue("nand", 4'h3, 8'hFF, 8'hFF, 8'h00, 8'h00, 0);

        issue("shl3", 4'h4, 8'hA1, 8'h00, 8'h03, 8'h00, 0);
`ifdef ALU_SHIFT_MULTI_EN
        check("shl3:lit_result", 32'(last_res), 32'h08);
`else
        check("shl3:lit_result", 32'(last_res), 32'h42);
`endif
        check("shl3:lit_carry", 32'(last_flags[0]), 32'h1);
        issue("shr0", 4'h5, 8'h81, 8'h00, 8'h00, 8'h00, 0);
        issue("shr7", 4'h5, 8'h81, 8'h00, 8'h07, 8'h00, 0);
        issue("shl7", 4'h4, 8'h81, 8'h00, 8'hFF, 8'h00, 0);

        for (int k = 0; k < 8; k++) begin
            issue("rand", 4'($urandom_range(0, 15)), W'($urandom), W'($urandom),
                  W'($urandom), W'($urandom), int'($urandom_range(0, 1)));
        end

        // asynchronous reset while a result is waiting
        bus.mode = 4'h1; bus.s1 = 8'hF0; bus.s2 = 8'h10; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_done:pre_valid", 32'(bus.out_valid), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("rst_done:out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_done:result", 32'(bus.result), 32'h0);
        check("rst_done:flags", 32'(bus.flags), 32'h0);
        check("rst_done:in_ready", 32'(bus.in_ready), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        mflags = 3'b000;

`ifdef ALU_SHIFT_MULTI_EN
        bus.mode = 4'h4; bus.s1 = 8'hFF; bus.imm = 8'h06; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_shift:pre_busy", 32'(bus.busy), 32'h1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_shift:busy", 32'(bus.busy), 32'h0);
        check("rst_shift:out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_shift:result", 32'(bus.result), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        mflags = 3'b000;
        @(negedge clk);
        check("rst_shift:no_result", 32'(bus.out_valid), 32'h0);
        @(posedge clk); #1;
`endif

        issue("add_again", 4'h1, 8'hF0, 8'h10, 8'h00, 8'h00, 0);
        issue("undef9", 4'h9, 8'h12, 8'h34, 8'h56, 8'h78, 0);
        check("undef9:lit_result", 32'(last_res), 32'h00);
        check("undef9:lit_flags", 32'(last_flags), 32'h5);
        issue("after_undef", 4'h1, 8'h01, 8'h02, 8'h00, 8'h00, 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised, registered successor of the single-cycle 8-bit execute ALU.
- Accepts one operation per valid/ready handshake and returns a registered result plus a persistent flag register.
- Adds multi-bit iterative shifts and backpressure.
- Sits between the decode/register-read stage and writeback.

Parameters:
WIDTH, 8, datapath width of s1, s2, imm, ex_in and result
SHW, 3, width of the shift-amount field taken from imm[SHW-1:0]; must satisfy 2**SHW >= WIDTH

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operation presented
in_ready  output  1  unit can accept an operation
mode  input  4  opcode
s1  input  WIDTH  first operand (ra)
s2  input  WIDTH  second operand (rb)
imm  input  WIDTH  immediate; low SHW bits are the shift amount
ex_in  input  WIDTH  external input port value
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
flags  output  3  {Z,N,C}, registered, persistent
busy  output  1  high while in SHIFT state

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, result=0, flags=3'b000, out_valid=0, busy=0, shift counter=0. in_ready=0 while rst is high.
- FSM states:
  - IDLE: in_ready=1.
  - SHIFT: iterative shift in progress; in_ready=0.
  - DONE: out_valid=1; in_ready=0.
- Accept condition: in_valid & in_ready.
  - Opcodes 4/5 with a nonzero shift amount go to SHIFT.
  - All other accepted opcodes write result/flags and go to DONE.
  - Single-cycle latency: out_valid rises the cycle after acceptance.
- DONE: holds result, flags and out_valid until out_ready=1, then returns to IDLE. No new acceptance occurs in the same cycle (one op in flight; throughput ≤ 1 op per 2 cycles).
- Opcodes:
  - 7 IN: result=ex_in.
  - E STORE: result=s1.
  - F LOADIMM: result=imm.
  - 8 MOVE: result=s2.
  - 1 ADD: result=s1+s2 (mod 2**WIDTH). C=carry out.
  - 2 SUB: result=s1-s2. C=borrow (s1<s2 unsigned).
  - 3 NAND: result=~(s1&s2). C=0.
  - 4 SHL: result=s1<<amt. C=last bit shifted out of the MSB.
  - 5 SHR: logical shift, result=s1>>amt. C=last bit shifted out of the LSB.
  - Other opcodes (0, 6, 9–D): result=0, flags unchanged, still complete via DONE (no hang).
- Flag update: Z=(result==0), N=result[WIDTH-1]. Updated only by opcodes 1–5; opcodes 7, 8, E, F and undefined opcodes leave flags unchanged.
- Shift amount: amt=imm[SHW-1:0].
  - amt=0: result=s1, C=0, Z/N from s1, single-cycle path.
  - amt ≥ WIDTH: result=0; C=the last bit shifted out, i.e. s1[0] for SHL at amt=WIDTH and 0 beyond that (matches bit-serial semantics).
- SHIFT state: one bit per cycle; counter loads amt, decrements to 0, then moves to DONE. Latency = amt+1 cycles from acceptance to out_valid. busy=1 exactly during SHIFT.
- Operands are captured at acceptance. Input changes after acceptance have no effect.
- rst asserted mid-SHIFT or mid-DONE: operation abandoned, all outputs return to reset values immediately.
- All arithmetic is unsigned WIDTH-bit. The carry is computed on a WIDTH+1-bit sum.

Optional Feature:
ALU_SHIFT_MULTI_EN
- Defined: multi-bit iterative shifts as described above, using the SHIFT state and the counter.
- Not defined: SHL/SHR always shift by exactly 1 in a single cycle; imm is ignored for shifts. The SHIFT state and counter are not synthesised, busy is tied to 0, and C = s1[WIDTH-1] (SHL) or s1[0] (SHR).

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> result=0, flags=000, out_valid=0 before the next edge. Deassert -> in_ready=1.
- ADD: s1=8'hF0, s2=8'h10, mode=1 -> next cycle out_valid=1, result=8'h00, flags Z=1 N=0 C=1. Hold out_ready=0 for 3 cycles -> result stable, in_ready=0.
- SUB: s1=8'h03, s2=8'h05, mode=2 -> result=8'hFE, Z=0 N=1 C=1. Follow with LOADIMM imm=8'h00 -> result=8'h00, flags still 011.
- SHL with macro: s1=8'b1010_0001, imm=3, mode=4 -> busy=1 for 3 cycles, out_valid on cycle 4, result=8'b0000_1000, C=1. With the macro undefined -> result=8'h42, C=1 after 1 cycle.
- SHR boundary with macro: s1=8'h81, imm=0 -> result=8'h81, C=0, 1-cycle latency. Then imm=7 -> result=8'h01, C=0. Assert rst during SHIFT -> busy=0, out_valid=0, no result.
- Undefined opcode 9 with flags=101 -> out_valid after 1 cycle, result=0, flags remain 101. Next op is accepted normally.
